turbo_encoder: RTL
==================

Name: turbo_encoder

Overview:
- Transmit-side counterpart of the team's turbo decoder.
- Accepts one K-bit message block and encodes it with two identical recursive systematic convolutional (RSC) constituent encoders. The second encoder is fed through a fixed affine interleaver.
- Streams one {systematic, parity1, parity2} triple per accepted beat, then 3 trellis-termination beats.
- Sits between the message source and the channel/decoder bench; used to generate decoder stimulus.

Parameters:
- K, 16, message block length in bits (power of 2, ≥8)
- INTLV_A, 5, interleaver multiplier (must be odd so the map is a bijection mod K)
- INTLV_B, 3, interleaver offset

Ports:
- i_clk  input  1  clock, rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_start  input  1  start-of-block request; sampled at rising edge
- i_data  input  K  message block; bit i is message bit i, sent first when i=0
- o_busy  output  1  high from block accept until the last beat is consumed
- o_valid  output  1  output beat available
- i_ready  input  1  downstream accepts beat when o_valid && i_ready
- o_bits  output  3  {sys, p1, p2}, sys is the MSB
- o_tail  output  1  current beat is a termination beat
- o_last  output  1  current beat is the final (K+3th) beat

Behaviour:
- Reset (async, i_rst_n=0):
  - state=IDLE; both encoder states=3'b000; beat index=0; message register=0.
  - o_busy=0, o_valid=0, o_bits=0, o_tail=0, o_last=0.
  - Reset mid-block aborts the block immediately. No beats follow release.
- States and transitions:
  - IDLE: if i_start=1, latch i_data, clear both encoder states, idx=0, go to ENC. Otherwise stay.
  - ENC: on handshake, update both encoders and idx++. Handshake at idx=K-1 → TAIL with idx=0.
  - TAIL: on handshake, idx++. Handshake at idx=2 → IDLE.
  - No handshake → hold everything.
- i_start while o_busy=1 is ignored; i_data is not re-latched.
- Outputs are functions of registered state only; no combinational path from any input to any output.
  - o_valid = o_busy = (state≠IDLE).
  - First beat is valid in the cycle after the accepting edge (latency 1).
- RSC encoder, state {s1,s2,s3}, where s1 is the most recent bit:
  - feedback a = u^s2^s3
  - parity p = a^s1^s3
  - next state = {a,s1,s2}
  - Transfer function: 1+D^2+D^3 feedback, 1+D+D^3 forward.
- Interleaver: pi(i) = (INTLV_A*i + INTLV_B) mod K, computed with K-bit-wide wraparound arithmetic.
- ENC beat idx:
  - encoder1 input u1 = msg[idx]; encoder2 input u2 = msg[pi(idx)].
  - o_bits = {u1, p(enc1,u1), p(enc2,u2)}.
- TAIL beat:
  - Each encoder's input is its own s2^s3, so a=0.
  - o_bits = {enc1 tail input, enc1 s1^s3, enc2 s1^s3}; encoder2's tail input bit is not transmitted.
  - o_tail=1.
  - After 3 tail beats both states are 3'b000; the verifier checks this via hierarchical probe.
- o_last=1 only on TAIL idx=2.
- Total: K+3 beats per block.
- Backpressure: i_ready may toggle at any time. o_bits, o_tail and o_last stay stable while o_valid && !i_ready.
- Back-to-back blocks: i_start sampled in the same cycle as the last handshake is ignored (state is not yet IDLE). Earliest accept is the next cycle.

Test Plan:
- Reset, i_data=16'h0000, i_start pulse, i_ready=1 → 19 beats, all o_bits=3'b000; o_tail on beats 16-18; o_last on beat 18 only; o_busy low after.
- i_data=16'h0001 (the 1 enters encoder2 at idx 9, since pi(9)=0) → beat0 o_bits=3'b110, beat1 3'b010, beat2 3'b010, beat3 3'b010; beat9 p2=1; both encoder states 000 after beat 18.
- Blocks 16'hF2CF, 16'hF64F, 16'h83C1, 16'h9C58, 16'h6A4C back-to-back → every beat matches the bit-exact reference model; 95 beats total; one cycle idle between blocks.
- Random i_ready (≈50% duty) with 16'hF2CF → identical beat sequence to the i_ready=1 case; outputs held stable during stalls.
- i_start with i_data=16'hFFFF during beat 5 of block 16'h0000 → ignored; remaining beats stay all-zero.
- Assert i_rst_n=0 mid-ENC (beat 7) → all outputs 0 asynchronously. After release, no beats until a new i_start; the new block starts at beat 0 with clean encoder state.

Source files
------------

// File: rtl/turbo_encoder_if.sv
// Block-in / beat-out handshake bundle for the turbo encoder.
// The message source and the beat sink share one interface instance.
interface turbo_encoder_if #(
    parameter int K = 16
);
    logic         i_start;
    logic [K-1:0] i_data;
    logic         o_busy;
    logic         o_valid;
    logic         i_ready;
    logic [2:0]   o_bits;
    logic         o_tail;
    logic         o_last;

    modport master (
        output i_start, i_data, i_ready,
        input  o_busy, o_valid, o_bits, o_tail, o_last
    );

    modport slave (
        input  i_start, i_data, i_ready,
        output o_busy, o_valid, o_bits, o_tail, o_last
    );
endinterface

// File: rtl/turbo_encoder.sv
// Two-RSC parallel turbo encoder with an affine interleaver.
// Streams K {sys,p1,p2} beats followed by 3 termination beats.
module turbo_encoder #(
    parameter int K       = 16,
    parameter int INTLV_A = 5,
    parameter int INTLV_B = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    turbo_encoder_if.slave   bus
);
    localparam int IW = $clog2(K);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ENC,
        S_TAIL
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [K-1:0]  r_msg, w_msg_nxt;
    logic [IW-1:0] r_idx, w_idx_nxt;
    logic [2:0]    r_st1, w_st1_nxt;
    logic [2:0]    r_st2, w_st2_nxt;

    logic [IW-1:0] w_pi;
    logic          w_busy, w_tail, w_hs;
    logic          w_u1, w_u2;
    logic          w_a1, w_a2;
    logic          w_p1, w_p2;

    // K is a power of two, so IW-bit wraparound is exactly mod K
    assign w_pi   = IW'(INTLV_A) * r_idx + IW'(INTLV_B);
    assign w_busy = (r_state != S_IDLE);
    assign w_tail = (r_state == S_TAIL);
    assign w_hs   = w_busy && bus.i_ready;

    // State layout {s1,s2,s3}; tail input s2^s3 forces a=0
    always_comb begin
        w_u1 = w_tail ? (r_st1[1] ^ r_st1[0]) : r_msg[r_idx];
        w_u2 = w_tail ? (r_st2[1] ^ r_st2[0]) : r_msg[w_pi];
        w_a1 = w_u1 ^ r_st1[1] ^ r_st1[0];
        w_a2 = w_u2 ^ r_st2[1] ^ r_st2[0];
        w_p1 = w_a1 ^ r_st1[2] ^ r_st1[0];
        w_p2 = w_a2 ^ r_st2[2] ^ r_st2[0];
    end

    always_comb begin
        w_state_nxt = r_state;
        w_msg_nxt   = r_msg;
        w_idx_nxt   = r_idx;
        w_st1_nxt   = r_st1;
        w_st2_nxt   = r_st2;
        unique case (r_state)
            S_IDLE: begin
                if (bus.i_start) begin
                    w_state_nxt = S_ENC;
                    w_msg_nxt   = bus.i_data;
                    w_idx_nxt   = '0;
                    w_st1_nxt   = '0;
                    w_st2_nxt   = '0;
                end
            end
            S_ENC: begin
                if (w_hs) begin
                    w_st1_nxt = {w_a1, r_st1[2:1]};
                    w_st2_nxt = {w_a2, r_st2[2:1]};
                    w_idx_nxt = r_idx + 1'b1;
                    if (r_idx == IW'(K - 1)) begin
                        w_state_nxt = S_TAIL;
                        w_idx_nxt   = '0;
                    end
                end
            end
            S_TAIL: begin
                if (w_hs) begin
                    w_st1_nxt = {w_a1, r_st1[2:1]};
                    w_st2_nxt = {w_a2, r_st2[2:1]};
                    w_idx_nxt = r_idx + 1'b1;
                    if (r_idx == IW'(2)) begin
                        w_state_nxt = S_IDLE;
                        w_idx_nxt   = '0;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_msg   <= '0;
            r_idx   <= '0;
            r_st1   <= '0;
            r_st2   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_msg   <= w_msg_nxt;
            r_idx   <= w_idx_nxt;
            r_st1   <= w_st1_nxt;
            r_st2   <= w_st2_nxt;
        end
    end

    assign bus.o_busy  = w_busy;
    assign bus.o_valid = w_busy;
    assign bus.o_bits  = w_busy ? {w_u1, w_p1, w_p2} : 3'b000;
    assign bus.o_tail  = w_tail;
    assign bus.o_last  = w_tail && (r_idx == IW'(2));
endmodule
